spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter RD_TURN, default 2: cycles between the last MOSI payload bit and the first MISO sample of a read-data frame, range 1..15.
REQ-002 Parameter GAP_CYC, default 1: minimum cycles SS_n is held high between frames, range 1..15.
REQ-003 clk  input  1  single clock, rising edge; all outputs registered on it.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  one-cycle request strobe, accepted only when busy=0.
REQ-006 cmd  input  2  frame command: 00 write-address, 01 write-data, 10 read-address, 11 read-data.
REQ-007 payload  input  8  address/data byte sent after cmd; don't-care content for cmd=11.
REQ-008 MISO  input  1  serial data returned by the slave.
REQ-009 SS_n  output  1  active-low slave select.
REQ-010 MOSI  output  1  serial data to the slave, MSB first.
REQ-011 busy  output  1  high from the cycle after start acceptance until GAP ends.
REQ-012 done  output  1  one-cycle pulse at frame completion.
REQ-013 rd_data  output  8  byte captured during a read-data frame.
REQ-014 rd_valid  output  1  one-cycle pulse, rd_data valid; coincident with done for cmd=11.
REQ-015 err  output  1  sticky request-dropped flag (see Configuration).
REQ-016 err_clr  input  1  synchronous clear of err.

Function
REQ-017 Accepted start latches word[9:0]={cmd,payload}; inputs are ignored thereafter until the next acceptance.
REQ-018 States: IDLE, SEL, SHIFT, TURN, RECV, GAP; only IDLE accepts start.
REQ-019 IDLE: SS_n=1, MOSI=0; start=1 -> SEL next cycle, busy=1.
REQ-020 SEL (1 cycle): SS_n=0, MOSI=word[9] (command-select bit); -> SHIFT.
REQ-021 SHIFT (10 cycles): SS_n=0, MOSI=word[9],word[8],...,word[0] one bit per cycle; afterwards -> TURN if cmd=11, else -> GAP.
REQ-022 TURN (RD_TURN cycles): SS_n=0, MOSI=0; -> RECV.
REQ-023 RECV (8 cycles): SS_n=0, MOSI=0; MISO sampled each rising edge into a shift register, first sample is rd_data[7]; -> GAP.
REQ-024 GAP (GAP_CYC cycles): SS_n=1, MOSI=0; done pulses in the first GAP cycle; for cmd=11, rd_data updated and rd_valid pulses in the same cycle; busy falls when GAP ends, -> IDLE.
REQ-025 SS_n low duration: exactly 11 cycles for cmd 00/01/10; exactly 19+RD_TURN cycles for cmd 11.
REQ-026 rd_data holds its last value until the next read-data frame completes; it is never updated by cmd 00/01/10.
REQ-027 start while busy=1 is ignored; the frame in flight is unaffected.
REQ-028 Bit and turnaround counters are 4 bits wide, never wrap mid-state, and reload on every state entry.

Reset
REQ-029 rst_n low, at any time including mid-frame: state=IDLE, SS_n=1, MOSI=0, busy=0, done=0, rd_valid=0, rd_data=0, err=0, counters=0; the aborted frame produces no done.
REQ-030 After rst_n deasserts, start is accepted on the first rising edge.

Configuration
REQ-031 Macro SPI_MASTER_ERR_EN defined: err sets on start=1 while busy=1 and holds until err_clr=1 or reset; set wins over a simultaneous err_clr.
REQ-032 Macro SPI_MASTER_ERR_EN undefined: err is constant 0, err_clr is ignored, and no error logic is present.

Verification
REQ-033 Write-address: start with cmd=00, payload=0xA5 -> SS_n low 11 cycles, MOSI=0,0,0,1,0,1,0,0,1,0,1, done once, no rd_valid.
REQ-034 Read-data, RD_TURN=2: cmd=11, model drives MISO=0x3C after turnaround -> SS_n low 21 cycles, rd_data=0x3C, rd_valid and done coincide.
REQ-035 Back-to-back frames: start asserted in the cycle busy falls, GAP_CYC=3 -> SS_n high exactly 3 cycles between frames.
REQ-036 start pulsed during SHIFT -> ignored, frame unchanged; with SPI_MASTER_ERR_EN, err=1 until err_clr, else err stays 0.
REQ-037 rst_n asserted in the 4th RECV cycle -> SS_n=1 immediately, no done, rd_data=0, next frame completes normally.
REQ-038 Loopback to the team's SPI slave with RAM: write addr 0x10, write data 0x5A, read addr 0x10, read data -> rd_data=0x5A.

Source files
------------

// File: rtl/spi_master.sv
// SPI command master: SEL + 10-bit {cmd,payload} shift, optional turnaround/receive, then SS_n gap.
// Optional sticky request-dropped flag: define SPI_MASTER_ERR_EN.
module spi_master #(
    parameter int RD_TURN = 2,
    parameter int GAP_CYC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [1:0] i_cmd,
    input  logic [7:0] i_payload,
    input  logic       i_miso,
    input  logic       i_err_clr,
    output logic       o_ss_n,
    output logic       o_mosi,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_rd_data,
    output logic       o_rd_valid,
    output logic       o_err
);

    localparam logic [3:0] TURN_LD   = 4'(RD_TURN - 1);
    localparam logic [3:0] GAP_LD    = 4'(GAP_CYC - 1);
    localparam logic       GAP_MULTI = (GAP_CYC > 1);

    typedef enum logic [2:0] {S_IDLE, S_SEL, S_SHIFT, S_TURN, S_RECV, S_GAP} state_t;

    state_t     r_state;
    logic [9:0] r_word;
    logic [3:0] r_cnt;
    logic [6:0] r_sh;
    logic       r_ss_n, r_mosi, r_busy, r_done, r_rd_valid;
    logic [7:0] r_rd_data;

    // busy drops in the last GAP cycle, so a start there chains frames with exactly GAP_CYC high cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_word     <= '0;
            r_cnt      <= '0;
            r_sh       <= '0;
            r_ss_n     <= 1'b1;
            r_mosi     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_GAP: begin
                    if (r_busy) begin
                        r_cnt  <= r_cnt - 4'd1;
                        r_busy <= (r_cnt != 4'd1);
                    end else if (i_start) begin
                        r_state <= S_SEL;
                        r_word  <= {i_cmd, i_payload};
                        r_busy  <= 1'b1;
                        r_ss_n  <= 1'b0;
                        r_mosi  <= i_cmd[1];
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SEL: begin
                    r_state <= S_SHIFT;
                    r_mosi  <= r_word[9];
                    r_cnt   <= 4'd9;
                end
                S_SHIFT: begin
                    if (r_cnt != 4'd0) begin
                        r_mosi <= r_word[r_cnt - 4'd1];
                        r_cnt  <= r_cnt - 4'd1;
                    end else if (r_word[9:8] == 2'b11) begin
                        r_state <= S_TURN;
                        r_mosi  <= 1'b0;
                        r_cnt   <= TURN_LD;
                    end else begin
                        r_state <= S_GAP;
                        r_mosi  <= 1'b0;
                        r_ss_n  <= 1'b1;
                        r_done  <= 1'b1;
                        r_cnt   <= GAP_LD;
                        r_busy  <= GAP_MULTI;
                    end
                end
                S_TURN: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state <= S_RECV;
                        r_cnt   <= 4'd7;
                    end
                end
                S_RECV: begin
                    r_sh <= {r_sh[5:0], i_miso};
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state    <= S_GAP;
                        r_ss_n     <= 1'b1;
                        r_done     <= 1'b1;
                        r_rd_valid <= 1'b1;
                        r_rd_data  <= {r_sh, i_miso};
                        r_cnt      <= GAP_LD;
                        r_busy     <= GAP_MULTI;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_ss_n     = r_ss_n;
    assign o_mosi     = r_mosi;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_rd_valid = r_rd_valid;
    assign o_rd_data  = r_rd_data;

`ifdef SPI_MASTER_ERR_EN
    logic r_err;

    // a dropped request outranks a clear in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_err <= 1'b0;
        else if (i_start && r_busy)
            r_err <= 1'b1;
        else if (i_err_clr)
            r_err <= 1'b0;
    end

    assign o_err = r_err;
`else
    logic w_unused_err_clr;
    assign w_unused_err_clr = i_err_clr;
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with a negedge SPI slave model (address register + RAM).
module tb_spi_master;
    localparam int RD_TURN = 2;
    localparam int GAP_CYC = 3;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, miso = 1'b0, err_clr = 1'b0;
    logic [1:0] cmd = '0;
    logic [7:0] payload = '0;
    logic       ss_n, mosi, busy, done, rd_valid, err;
    logic [7:0] rd_data;

    spi_master #(.RD_TURN(RD_TURN), .GAP_CYC(GAP_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_cmd(cmd), .i_payload(payload),
        .i_miso(miso), .i_err_clr(err_clr), .o_ss_n(ss_n), .o_mosi(mosi), .o_busy(busy),
        .o_done(done), .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_err(err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // slave model + frame monitor, sampled mid-cycle
    int          k = 0, last_len = 0, hi_run = 0, last_hi = 0;
    int          n_done = 0, n_rv = 0, n_split = 0;
    logic [10:0] bits = '0, last_bits = '0;
    logic [7:0]  sl_addr = '0, b;
    logic [7:0]  sl_mem [256];

    always @(negedge clk) begin
        if (done) n_done++;
        if (rd_valid) n_rv++;
        if (rd_valid && !done) n_split++;
        if (!ss_n) begin
            if (k == 0) last_hi = hi_run;
            hi_run = 0;
            if (k < 11) bits = {bits[9:0], mosi};
            if (k >= 11 + RD_TURN && k < 19 + RD_TURN) begin
                b    = sl_mem[sl_addr];
                miso = b[7 - (k - 11 - RD_TURN)];
            end else begin
                miso = 1'b0;
            end
            k++;
        end else begin
            hi_run++;
            miso = 1'b0;
            if (k > 0) begin
                last_len  = k;
                last_bits = bits;
                case (bits[9:8])
                    2'b00, 2'b10: sl_addr = bits[7:0];
                    2'b01:        sl_mem[sl_addr] = bits[7:0];
                    default: ;
                endcase
                k = 0;
            end
        end
    end

    // called #1 after a rising edge; returns #1 after the edge where busy is low
    task automatic frame(input logic [1:0] c, input logic [7:0] p, input int poke);
        cmd = c; payload = p; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cmd = '0; payload = '0;
        if (poke > 0) begin
            repeat (poke) @(posedge clk);
            #1;
            start = 1'b1; cmd = 2'b11; payload = 8'hFF;
            @(posedge clk); #1;
            start = 1'b0; cmd = '0; payload = '0;
        end
        for (int i = 0; i < 200 && busy; i++) begin
            @(posedge clk); #1;
        end
        chk("busy_end", busy, 0);
    endtask

    int nd, nr;

    initial begin
        for (int i = 0; i < 256; i++) sl_mem[i] = 8'h00;
        sl_mem[8'h20] = 8'h3C;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ss_n", ss_n, 1);
        chk("rst_mosi", mosi, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rv", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_err", err, 0);

        // write-address 0xA5, started on the first edge after reset release
        rst_n = 1'b1;
        nd = n_done; nr = n_rv;
        frame(2'b00, 8'hA5, 0);
        chk("wa_len", last_len, 11);
        chk("wa_bits", last_bits, 11'h0A5);
        chk("wa_done", n_done - nd, 1);
        chk("wa_rv", n_rv - nr, 0);
        chk("wa_rd_data", rd_data, 0);

        // read-address then read-data, back to back
        frame(2'b10, 8'h20, 0);
        nd = n_done; nr = n_rv;
        frame(2'b11, 8'h00, 0);
        chk("rd_gap", last_hi, GAP_CYC);
        chk("rd_len", last_len, 19 + RD_TURN);
        chk("rd_data", rd_data, 8'h3C);
        chk("rd_rv", n_rv - nr, 1);
        chk("rd_done", n_done - nd, 1);
        chk("rd_split", n_split, 0);

        // write-data leaves rd_data alone
        nr = n_rv;
        frame(2'b01, 8'h77, 0);
        chk("wd_bits", last_bits, 11'h177);
        chk("wd_rv", n_rv - nr, 0);
        chk("wd_hold", rd_data, 8'h3C);

        // start pulsed mid-SHIFT is dropped
        nd = n_done;
        frame(2'b00, 8'h10, 3);
        chk("pk_len", last_len, 11);
        chk("pk_bits", last_bits, 11'h010);
        chk("pk_done", n_done - nd, 1);
`ifdef SPI_MASTER_ERR_EN
        chk("pk_err", err, 1);
`else
        chk("pk_err", err, 0);
`endif
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("clr_err", err, 0);

        // loopback: addr 0x10 <- 0x5A, read back
        frame(2'b00, 8'h10, 0);
        frame(2'b01, 8'h5A, 0);
        chk("lb_wd_bits", last_bits, 11'h15A);
        frame(2'b10, 8'h10, 0);
        frame(2'b11, 8'h00, 0);
        chk("lb_rd_data", rd_data, 8'h5A);

        // reset in the 4th RECV cycle of a read-data frame
        cmd = 2'b11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cmd = '0;
        repeat (16) @(posedge clk);
        #1;
        chk("ab_ss_pre", ss_n, 0);
        nd = n_done;
        rst_n = 1'b0;
        #1;
        chk("ab_ss_n", ss_n, 1);
        chk("ab_busy", busy, 0);
        chk("ab_rd_data", rd_data, 0);
        chk("ab_mosi", mosi, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("ab_no_done", n_done - nd, 0);
        rst_n = 1'b1;
        nd = n_done;
        frame(2'b11, 8'h00, 0);
        chk("ar_len", last_len, 19 + RD_TURN);
        chk("ar_rd_data", rd_data, 8'h5A);
        chk("ar_done", n_done - nd, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
